// File: rtl/acq_sequencer.sv
// Sequences one acquisition into a circular sample buffer: pre-trigger fill, arm, post-trigger fill, done.
// Build with AUTO_TRIG_EN defined to get the auto-trigger timeout; otherwise i_auto is ignored.
module acq_sequencer #(
    parameter int ADDR_W       = 10,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_auto,
    input  logic [ADDR_W-1:0] i_pretrig,
    input  logic              i_sample_valid,
    input  logic              i_trigger,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [ADDR_W-1:0] o_trig_addr,
    output logic              o_auto_fired
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   P_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [ADDR_W-1:0]   r_pretrig;
    logic [ADDR_W-1:0]   r_pre_cnt;
    logic [ADDR_W:0]     r_post_cnt;
    logic [ADDR_W:0]     w_post_rem;
    logic                w_fire;
    logic                w_start;

    assign w_start = i_start & ~i_stop;
    // Post writes still owed after the trigger sample itself has been written.
    assign w_post_rem = DEPTH_V - {1'b0, r_pretrig} - P_ONE;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_auto;
    logic            r_auto_pend;
    logic            r_auto_fired;

    assign w_fire       = i_sample_valid & (i_trigger | r_auto_pend);
    assign o_auto_fired = r_auto_fired;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt     <= '0;
            r_auto       <= 1'b0;
            r_auto_pend  <= 1'b0;
            r_auto_fired <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_to_cnt    <= '0;
            r_auto_pend <= 1'b0;
            if (w_start) begin
                r_auto       <= i_auto;
                r_auto_fired <= 1'b0;
            end
        end else if (r_state == S_ARMED && !i_stop) begin
            if (w_fire) begin
                // A genuine trigger on the pending sample takes credit for the capture.
                r_auto_fired <= r_auto_pend & ~i_trigger;
                r_auto_pend  <= 1'b0;
                r_to_cnt     <= '0;
            end else if (r_auto && !r_auto_pend) begin
                if (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1)) begin
                    r_auto_pend <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end
`else
    logic w_unused_auto;

    assign w_unused_auto = i_auto;
    assign w_fire        = i_sample_valid & i_trigger;
    assign o_auto_fired  = 1'b0;
`endif

    assign o_wr_en = i_sample_valid &
                     ((r_state == S_PREFILL) | (r_state == S_ARMED) | (r_state == S_POST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_addr   <= '0;
            r_trig_addr <= '0;
            r_pretrig   <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pretrig <= i_pretrig;
                        r_wr_addr <= '0;
                        r_pre_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= (i_pretrig == '0) ? S_ARMED : S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    if (i_stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_sample_valid) begin
                        r_wr_addr <= r_wr_addr + A_ONE;
                        r_pre_cnt <= r_pre_cnt + A_ONE;
                        if (r_pre_cnt + A_ONE == r_pretrig) begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (i_stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_fire) begin
                        r_trig_addr <= r_wr_addr;
                        r_wr_addr   <= r_wr_addr + A_ONE;
                        r_post_cnt  <= w_post_rem;
                        if (w_post_rem == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_POST;
                        end
                    end else if (i_sample_valid) begin
                        r_wr_addr <= r_wr_addr + A_ONE;
                    end
                end
                S_POST: begin
                    if (i_stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_sample_valid) begin
                        r_wr_addr <= r_wr_addr + A_ONE;
                        if (r_post_cnt == P_ONE) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_post_cnt <= r_post_cnt - P_ONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_stop) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_wr_addr   = r_wr_addr;
    assign o_trig_addr = r_trig_addr;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected writes and capture results are queued by the stimulus
// and consumed by a negedge monitor whenever the DUT writes or raises o_done.
module tb_acq_sequencer;
    localparam int AW = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic          i_stop;
    logic          i_auto;
    logic [AW-1:0] i_pretrig;
    logic          i_sample_valid;
    logic          i_trigger;
    logic          o_busy;
    logic          o_done;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [AW-1:0] o_trig_addr;
    logic          o_auto_fired;

    acq_sequencer #(
        .ADDR_W      (AW),
        .AUTO_TIMEOUT(8)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_auto        (i_auto),
        .i_pretrig     (i_pretrig),
        .i_sample_valid(i_sample_valid),
        .i_trigger     (i_trigger),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_trig_addr   (o_trig_addr),
        .o_auto_fired  (o_auto_fired)
    );

    typedef struct packed {
        logic [AW-1:0] trig;
        logic [AW-1:0] wr;
        logic          af;
    } done_t;

    logic [AW-1:0] exp_wr[$];
    done_t         exp_done[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_done = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every buffer write and every rising o_done is matched against the scoreboard.
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_write: write to addr %0d, none expected", o_wr_addr);
            end else begin
                check("wr_addr", o_wr_addr, exp_wr.pop_front());
            end
        end
        if (o_done && !prev_done) begin
            if (exp_done.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: o_done rose, no capture expected");
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_trig_addr", o_trig_addr, d.trig);
                check("done_wr_addr", o_wr_addr, d.wr);
                check("done_auto_fired", o_auto_fired, d.af);
                check("done_busy", o_busy, 1);
            end
        end
        prev_done <= o_done;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_writes(input int first, input int n);
        for (int k = 0; k < n; k++) exp_wr.push_back(AW'((first + k) % 16));
    endtask

    task automatic push_done(input int t, input int w, input logic a);
        done_t d;
        d.trig = AW'(t);
        d.wr   = AW'(w);
        d.af   = a;
        exp_done.push_back(d);
    endtask

    task automatic start_cap(input int pt, input logic au);
        i_pretrig = AW'(pt);
        i_auto    = au;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic stop_cap();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("done_after_stop", o_done, 0);
        check("busy_after_stop", o_busy, 0);
    endtask

    // n valid samples, each preceded by gap-1 idle cycles; tmask bit k raises i_trigger on sample k.
    task automatic feed(input int n, input int gap, input logic [63:0] tmask, input logic tgap);
        for (int k = 0; k < n; k++) begin
            for (int g = 1; g < gap; g++) begin
                i_sample_valid = 1'b0;
                i_trigger      = tgap;
                tick();
            end
            i_sample_valid = 1'b1;
            i_trigger      = tmask[k];
            tick();
        end
        i_sample_valid = 1'b0;
        i_trigger      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_start        = 1'b0;
        i_stop         = 1'b0;
        i_auto         = 1'b0;
        i_pretrig      = '0;
        i_sample_valid = 1'b0;
        i_trigger      = 1'b0;
        idle(2);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_trig_addr", o_trig_addr, 0);
        check("rst_auto_fired", o_auto_fired, 0);
        i_rst_n = 1'b1;
        idle(1);

        // start together with stop must not begin a capture
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        check("start_stop_idle", o_busy, 0);

        // normal capture, trigger at addr 9
        start_cap(4, 1'b0);
        push_writes(0, 21);
        push_done(9, 5, 1'b0);
        feed(21, 1, 64'h200, 1'b0);
        feed(3, 1, 64'h0, 1'b0);
        check("t1_done", o_done, 1);
        stop_cap();

        // triggers during pre-fill are masked
        start_cap(4, 1'b0);
        push_writes(0, 18);
        push_done(6, 2, 1'b0);
        feed(18, 1, 64'h4F, 1'b0);
        idle(2);
        check("t2_done", o_done, 1);
        stop_cap();

        // zero pre-trigger
        start_cap(0, 1'b0);
        push_writes(0, 16);
        push_done(0, 0, 1'b0);
        feed(16, 1, 64'h1, 1'b0);
        idle(2);
        check("t3_done", o_done, 1);
        stop_cap();

        // auto mode with no trigger
        start_cap(2, 1'b1);
        push_writes(0, 24);
`ifdef AUTO_TRIG_EN
        push_done(10, 8, 1'b1);
`endif
        feed(24, 1, 64'h0, 1'b0);
        idle(2);
`ifdef AUTO_TRIG_EN
        check("t4_auto_done", o_done, 1);
        check("t4_auto_fired", o_auto_fired, 1);
`else
        check("t4_auto_done", o_done, 0);
`endif
        stop_cap();

        // normal mode waits indefinitely; i_auto raised after start has no effect
        start_cap(2, 1'b0);
        i_auto = 1'b1;
        check("t4b_auto_fired_clr", o_auto_fired, 0);
        push_writes(0, 100);
        feed(100, 1, 64'h0, 1'b0);
        check("t4b_done", o_done, 0);
        check("t4b_busy", o_busy, 1);
        stop_cap();
        i_auto = 1'b0;

        // gapped samples, trigger held high on non-valid cycles
        start_cap(3, 1'b0);
        push_writes(0, 18);
        push_done(5, 2, 1'b0);
        feed(18, 3, 64'h20, 1'b1);
        idle(2);
        check("t5_done", o_done, 1);
        stop_cap();

        // abort while armed
        start_cap(2, 1'b0);
        push_writes(0, 4);
        feed(4, 1, 64'h0, 1'b0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_trig_kept", o_trig_addr, 5);
        i_sample_valid = 1'b1;
        idle(2);
        i_sample_valid = 1'b0;

        // asynchronous reset during post-fill
        start_cap(1, 1'b0);
        push_writes(0, 5);
        feed(5, 1, 64'h2, 1'b0);
        i_sample_valid = 1'b1;
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        check("arst_wr_en", o_wr_en, 0);
        check("arst_wr_addr", o_wr_addr, 0);
        check("arst_trig_addr", o_trig_addr, 0);
        check("arst_auto_fired", o_auto_fired, 0);
        tick();
        i_sample_valid = 1'b0;
        i_rst_n        = 1'b1;
        idle(1);

        // restart with maximum pre-trigger: trigger sample is the only post write
        start_cap(15, 1'b0);
        push_writes(0, 16);
        push_done(15, 0, 1'b0);
        feed(16, 1, 64'h8000, 1'b0);
        idle(2);
        check("t7_done", o_done, 1);
        stop_cap();

        idle(2);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
